// File: rtl/muscle_sched_pkg.sv
// Shared types for the time-multiplexed muscle channel scheduler.
// Values are raw IEEE-754 single words; the scheduler never does arithmetic on them.
package muscle_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StCommit,
    StDone
  } sched_state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] x_i1;
    logic [31:0] x_i2;
    logic [31:0] y_i1;
    logic [31:0] y_i2;
    logic [31:0] T_i;
    logic [31:0] dT_i;
  } channel_state_t;

endpackage

// File: rtl/muscle_channel_scheduler_if.sv
// Bundle between the scheduler, the shared muscle datapath and the force consumers.
// master drives ticks and datapath results; slave is the scheduler.
interface muscle_channel_scheduler_if #(
  parameter int unsigned NUM_CH = 8
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic            i_tick;
  logic            i_clear;
  logic [CH_W-1:0] o_ch;
  logic [31:0]     o_x_i1;
  logic [31:0]     o_x_i2;
  logic [31:0]     o_y_i1;
  logic [31:0]     o_y_i2;
  logic [31:0]     o_T_i;
  logic [31:0]     o_dT_i;
  logic [31:0]     i_fp_spikes;
  logic [31:0]     i_h_i;
  logic [31:0]     i_T_next;
  logic [31:0]     i_dT_next;
  logic            o_force_we;
  logic [CH_W-1:0] o_force_ch;
  logic [31:0]     o_force;
  logic [31:0]     o_active;
  logic            o_busy;
  logic            o_done;
  logic            o_overrun;

  modport master (
    output i_tick, i_clear, i_fp_spikes, i_h_i, i_T_next, i_dT_next,
    input  o_ch, o_x_i1, o_x_i2, o_y_i1, o_y_i2, o_T_i, o_dT_i,
    input  o_force_we, o_force_ch, o_force, o_active, o_busy, o_done, o_overrun
  );

  modport slave (
    input  i_tick, i_clear, i_fp_spikes, i_h_i, i_T_next, i_dT_next,
    output o_ch, o_x_i1, o_x_i2, o_y_i1, o_y_i2, o_T_i, o_dT_i,
    output o_force_we, o_force_ch, o_force, o_active, o_busy, o_done, o_overrun
  );

endinterface

// File: rtl/muscle_state_bank.sv
// Per-channel delay-line and integrator state: combinational read of one channel,
// single write port that shifts the histories, synchronous clear of every channel.
module muscle_state_bank
  import muscle_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            we_i,
  input  logic [CH_W-1:0] ch_i,
  input  logic [31:0]     spikes_i,
  input  logic [31:0]     h_i,
  input  logic [31:0]     t_next_i,
  input  logic [31:0]     dt_next_i,
  output channel_state_t  rd_o
);

  channel_state_t mem_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        mem_q[i] <= '{default: FP_ZERO};
      end
    end else if (we_i) begin
      // Both histories shift in the same cycle as the integrator update.
      mem_q[ch_i].x_i2 <= mem_q[ch_i].x_i1;
      mem_q[ch_i].x_i1 <= spikes_i;
      mem_q[ch_i].y_i2 <= mem_q[ch_i].y_i1;
      mem_q[ch_i].y_i1 <= h_i;
      mem_q[ch_i].T_i  <= t_next_i;
      mem_q[ch_i].dT_i <= dt_next_i;
    end
  end

  assign rd_o = mem_q[ch_i];

endmodule

// File: rtl/muscle_channel_scheduler.sv
// Steps one shared muscle datapath across NUM_CH channels per tick: present operands,
// settle for SETTLE_CYCLES, then write results back to the state bank.
module muscle_channel_scheduler
  import muscle_sched_pkg::*;
#(
  parameter int unsigned NUM_CH        = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  muscle_channel_scheduler_if.slave bus
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  sched_state_e    state_q;
  logic [CH_W-1:0] ch_q;
  logic [CNT_W-1:0] cnt_q;
  logic            force_we_q;
  logic [CH_W-1:0] force_ch_q;
  logic [31:0]     force_q;
  logic [31:0]     active_q;
  logic            done_q;
  logic            overrun_q;
  logic            commit_we;
  channel_state_t  rd_state;

  // A clear in the commit cycle aborts the step before anything is written.
  assign commit_we = (state_q == StCommit) && !bus.i_clear;

  muscle_state_bank #(
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (bus.i_clear),
    .we_i     (commit_we),
    .ch_i     (ch_q),
    .spikes_i (bus.i_fp_spikes),
    .h_i      (bus.i_h_i),
    .t_next_i (bus.i_T_next),
    .dt_next_i(bus.i_dT_next),
    .rd_o     (rd_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      cnt_q      <= '0;
      force_we_q <= 1'b0;
      force_ch_q <= '0;
      force_q    <= FP_ZERO;
      active_q   <= FP_ZERO;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      force_we_q <= 1'b0;
      done_q     <= 1'b0;
      if (bus.i_clear) begin
        state_q   <= StIdle;
        ch_q      <= '0;
        overrun_q <= 1'b0;
      end else begin
        if (bus.i_tick && (state_q != StIdle)) overrun_q <= 1'b1;
        unique case (state_q)
          StIdle: begin
            if (bus.i_tick) begin
              ch_q    <= '0;
              cnt_q   <= CNT_LOAD;
              state_q <= StEval;
            end
          end
          StEval: begin
            if (cnt_q == '0) state_q <= StCommit;
            else             cnt_q   <= cnt_q - 1'b1;
          end
          StCommit: begin
            force_we_q <= 1'b1;
            force_ch_q <= ch_q;
            force_q    <= bus.i_T_next;
            active_q   <= bus.i_h_i;
            if (ch_q == LAST_CH) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              ch_q    <= ch_q + 1'b1;
              cnt_q   <= CNT_LOAD;
              state_q <= StEval;
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.o_ch       = ch_q;
  assign bus.o_x_i1     = rd_state.x_i1;
  assign bus.o_x_i2     = rd_state.x_i2;
  assign bus.o_y_i1     = rd_state.y_i1;
  assign bus.o_y_i2     = rd_state.y_i2;
  assign bus.o_T_i      = rd_state.T_i;
  assign bus.o_dT_i     = rd_state.dT_i;
  assign bus.o_force_we = force_we_q;
  assign bus.o_force_ch = force_ch_q;
  assign bus.o_force    = force_q;
  assign bus.o_active   = active_q;
  assign bus.o_busy     = (state_q != StIdle);
  assign bus.o_done     = done_q;
  assign bus.o_overrun  = overrun_q;

endmodule

// File: tb/tb_muscle_channel_scheduler.sv
// Bench for muscle_channel_scheduler: step-level reference model checked every cycle,
// a stub-datapath vector table, directed corner sequences and a random phase.
module tb_muscle_channel_scheduler;
  import muscle_sched_pkg::*;

  localparam int N        = 8;
  localparam int S        = 2;
  localparam int P        = S + 1;
  localparam int DONE_REL = N * P + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muscle_channel_scheduler_if #(.NUM_CH(N)) bus ();

  muscle_channel_scheduler #(
    .NUM_CH       (N),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] spikes;
    logic [31:0] exp_x1;
    logic [31:0] exp_x2;
    logic [31:0] exp_y1;
    logic [31:0] exp_y2;
    logic [31:0] exp_t;
  } vec_t;

  vec_t vecs [N];

  // Reference model: step position counted in cycles since the accepted tick.
  channel_state_t m_bank [N];
  bit          m_act, m_ovr, m_we, m_ch0, m_zero, stub;
  int          m_rel, m_fch;
  logic [31:0] m_force, m_actv;
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_ops(input string tag, input channel_state_t e);
    chk({tag, ".x_i1"}, bus.o_x_i1, e.x_i1);
    chk({tag, ".x_i2"}, bus.o_x_i2, e.x_i2);
    chk({tag, ".y_i1"}, bus.o_y_i1, e.y_i1);
    chk({tag, ".y_i2"}, bus.o_y_i2, e.y_i2);
    chk({tag, ".T_i"},  bus.o_T_i,  e.T_i);
    chk({tag, ".dT_i"}, bus.o_dT_i, e.dT_i);
  endtask

  task automatic model_clear_bank();
    for (int i = 0; i < N; i++) m_bank[i] = '{default: 32'h0};
    m_zero = 1'b1;
  endtask

  task automatic model_reset();
    model_clear_bank();
    m_act = 0; m_rel = 0; m_ovr = 0; m_we = 0; m_fch = 0;
    m_force = 32'h0; m_actv = 32'h0; m_ch0 = 1;
  endtask

  task automatic check_outputs();
    int ch;
    chk("busy",     32'(bus.o_busy),     32'(m_act));
    chk("done",     32'(bus.o_done),     32'(m_act && (m_rel == DONE_REL)));
    chk("overrun",  32'(bus.o_overrun),  32'(m_ovr));
    chk("force_we", 32'(bus.o_force_we), 32'(m_we));
    chk("force_ch", 32'(bus.o_force_ch), 32'(m_fch));
    chk("force",    bus.o_force,         m_force);
    chk("active",   bus.o_active,        m_actv);
    if (m_act) begin
      ch = (m_rel == DONE_REL) ? N - 1 : (m_rel - 1) / P;
      chk("ch", 32'(bus.o_ch), 32'(ch));
      chk_ops("ops", m_bank[ch]);
    end else if (m_ch0) begin
      chk("ch_idle", 32'(bus.o_ch), 32'h0);
      chk_ops("ops_idle", m_bank[0]);
    end else if (m_zero) begin
      chk_ops("ops_zero", '{default: 32'h0});
    end
  endtask

  task automatic model_update(input bit rst, input bit tick, input bit clr,
                              input logic [31:0] sp, input logic [31:0] h,
                              input logic [31:0] tn, input logic [31:0] dtn);
    bit commit;
    int k;
    if (rst) begin
      model_reset();
      return;
    end
    commit = m_act && !clr && (m_rel >= 1) && (m_rel <= N * P) && ((m_rel % P) == 0);
    m_we = commit;
    if (commit) begin
      k = m_rel / P - 1;
      m_bank[k].x_i2 = m_bank[k].x_i1;
      m_bank[k].x_i1 = sp;
      m_bank[k].y_i2 = m_bank[k].y_i1;
      m_bank[k].y_i1 = h;
      m_bank[k].T_i  = tn;
      m_bank[k].dT_i = dtn;
      m_fch = k; m_force = tn; m_actv = h; m_zero = 0;
    end
    if (clr) begin
      model_clear_bank();
      m_act = 0; m_ovr = 0;
    end else if (m_act) begin
      if (tick) m_ovr = 1;
      if (m_rel == DONE_REL) m_act = 0;
      else m_rel++;
    end else if (tick) begin
      m_act = 1; m_rel = 1; m_ch0 = 0;
    end
  endtask

  // Called at a negedge: check, drive, clock, update model, return at the next negedge.
  task automatic cyc(input bit tick, input bit clr, input bit rst);
    logic [31:0] sp, h, tn, dtn;
    check_outputs();
    if (stub) begin
      sp = vecs[bus.o_ch].spikes; h = 32'h4000_0000; tn = 32'h4040_0000; dtn = 32'h3F00_0000;
    end else begin
      sp = $urandom; h = $urandom; tn = $urandom; dtn = $urandom;
    end
    reset = rst; bus.i_tick = tick; bus.i_clear = clr;
    bus.i_fp_spikes = sp; bus.i_h_i = h; bus.i_T_next = tn; bus.i_dT_next = dtn;
    @(posedge clk);
    model_update(rst, tick, clr, sp, h, tn, dtn);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] fl [N];
    fl[0] = 32'h3F80_0000; fl[1] = 32'h4000_0000; fl[2] = 32'h4040_0000;
    fl[3] = 32'h4080_0000; fl[4] = 32'h40A0_0000; fl[5] = 32'h40C0_0000;
    fl[6] = 32'h40E0_0000; fl[7] = 32'h4100_0000;
    for (int i = 0; i < N; i++) begin
      vecs[i] = '{spikes: fl[i], exp_x1: fl[i], exp_x2: fl[i], exp_y1: 32'h4000_0000,
                  exp_y2: 32'h4000_0000, exp_t: 32'h4040_0000};
    end

    stub = 0;
    reset = 1'b1; bus.i_tick = 0; bus.i_clear = 0;
    bus.i_fp_spikes = 0; bus.i_h_i = 0; bus.i_T_next = 0; bus.i_dT_next = 0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);

    // Plain step: commit/done/busy timing against the model.
    cyc(1, 0, 0);
    repeat (DONE_REL + 2) cyc(0, 0, 0);

    // Stub datapath: two steps, then read each channel back from the vector table.
    stub = 1;
    repeat (2) begin
      cyc(1, 0, 0);
      repeat (DONE_REL + 1) cyc(0, 0, 0);
    end
    cyc(1, 0, 0);
    for (int k = 0; k < N; k++) begin
      chk("tbl.ch",   32'(bus.o_ch), 32'(k));
      chk("tbl.x_i1", bus.o_x_i1, vecs[k].exp_x1);
      chk("tbl.x_i2", bus.o_x_i2, vecs[k].exp_x2);
      chk("tbl.y_i1", bus.o_y_i1, vecs[k].exp_y1);
      chk("tbl.y_i2", bus.o_y_i2, vecs[k].exp_y2);
      chk("tbl.T_i",  bus.o_T_i,  vecs[k].exp_t);
      repeat (P) cyc(0, 0, 0);
    end
    repeat (2) cyc(0, 0, 0);
    stub = 0;

    // Tick during a step at t+10: ignored, overrun sticky, completion unchanged.
    cyc(1, 0, 0);
    repeat (9) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (DONE_REL + 2) cyc(0, 0, 0);
    chk("overrun_sticky", 32'(bus.o_overrun), 32'h1);

    // Clear at channel 3's first EVAL cycle.
    cyc(1, 0, 0);
    repeat (9) cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (3) cyc(0, 0, 0);
    chk("clr_busy",    32'(bus.o_busy),    32'h0);
    chk("clr_overrun", 32'(bus.o_overrun), 32'h0);
    chk("clr_x_i1",    bus.o_x_i1,         32'h0);

    // Tick and clear together while idle: nothing starts.
    cyc(1, 1, 0);
    repeat (3) cyc(0, 0, 0);
    chk("tc_busy", 32'(bus.o_busy), 32'h0);

    // Reset at channel 6's commit cycle after filling the bank.
    cyc(1, 0, 0);
    repeat (DONE_REL + 1) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (20) cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("rst_force_we", 32'(bus.o_force_we), 32'h0);
    chk("rst_ch",       32'(bus.o_ch),       32'h0);
    chk("rst_T_i",      bus.o_T_i,           32'h0);

    // Random ticks, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 499) == 0);
    end
    cyc(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
